// File: rtl/mesh_nn.sv
// mesh_nn: mesh endpoint around a dot-product MAC tile; remote packets fill memory and
// launch jobs, and each result goes back out as a packet to a programmable tile.
module mesh_nn #(
  parameter int x_cord_width_p = 2,
  parameter int y_cord_width_p = 2,
  parameter int data_width_p = 32,
  parameter int addr_width_p = 10,
  localparam int P = 2 + addr_width_p + data_width_p + 2 * (x_cord_width_p + y_cord_width_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [P+1:0]              link_sif_i,
  output logic [P+1:0]              link_sif_o,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic [x_cord_width_p-1:0] dest_x_i,
  input  logic [y_cord_width_p-1:0] dest_y_i
);
  typedef enum logic [1:0] {IDLE, MAC, SEND} state_t;
  typedef struct packed {
    logic [1:0]                op;
    logic [addr_width_p-1:0]   addr;
    logic [data_width_p-1:0]   data;
    logic [y_cord_width_p-1:0] sy;
    logic [x_cord_width_p-1:0] sx;
    logic [y_cord_width_p-1:0] dy;
    logic [x_cord_width_p-1:0] dx;
  } pkt_t;
  state_t st, nx;
  pkt_t ipk, opk;
  logic in_v, out_ready, out_v, in_ready, take, start, unused_ok;
  logic [addr_width_p-1:0] n, a, b, c;
  logic [data_width_p-1:0] acc, ra, rb;
  logic [data_width_p-1:0] mem [0:(1<<addr_width_p)-1];
  assign {in_v, ipk, out_ready} = link_sif_i;
  assign link_sif_o = {out_v, opk, in_ready};
  assign take = in_v && in_ready && ipk.dx == my_x_i && ipk.dy == my_y_i;
  assign start = take && ipk.op == 2'd1;
  assign unused_ok = ^{ipk.sy, ipk.sx};
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) st <= IDLE;
    else st <= nx;
  always_comb begin
    nx = st == IDLE ? (start ? (ipk.addr == '0 ? SEND : MAC) : IDLE) :
         st == MAC  ? (c == n ? SEND : MAC) :
                      (out_ready ? IDLE : SEND);
  end
  always_comb begin
    out_v = st == SEND;
    in_ready = st == IDLE && reset_i;
    opk = out_v ? pkt_t'{op: 2'd3, addr: n, data: acc, sy: my_y_i, sx: my_x_i,
                         dy: dest_y_i, dx: dest_x_i} : '0;
  end
  // Operands read here are consumed one cycle later, hence the N+1 MAC cycles.
  always_ff @(posedge clk_i) begin
    if (take && ipk.op == 2'd0) mem[ipk.addr] <= ipk.data;
    ra <= mem[a + c];
    rb <= mem[b + c];
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      n <= '0;
      a <= '0;
      b <= '0;
      c <= '0;
      acc <= '0;
    end else if (start) begin
      n <= ipk.addr;
      a <= ipk.data[addr_width_p-1:0];
      b <= ipk.data[16 +: addr_width_p];
      c <= '0;
      acc <= '0;
    end else if (st == MAC) begin
      c <= c + 1'b1;
      if (c != '0) acc <= acc + ra * rb;
    end
endmodule

// File: tb/tb_mesh_nn.sv
// tb_mesh_nn: directed vectors for the mesh_nn endpoint with hand-computed results.
module tb_mesh_nn;
  localparam int P = 52;
  logic clk = 0, reset_i = 0, in_v = 0, out_ready = 0;
  logic [P-1:0] in_pkt = '0;
  logic [1:0] my_x = 0, my_y = 0, dest_x = 1, dest_y = 1;
  wire [P+1:0] so;
  wire out_v = so[P+1];
  wire in_ready = so[0];
  wire [P-1:0] opk = so[P:1];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  mesh_nn dut (
    .clk_i(clk), .reset_i(reset_i), .link_sif_i({in_v, in_pkt, out_ready}), .link_sif_o(so),
    .my_x_i(my_x), .my_y_i(my_y), .dest_x_i(dest_x), .dest_y_i(dest_y)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input [1:0] op, input [9:0] addr, input [31:0] data, input [1:0] dy, input [1:0] dx);
    int k = 0;
    @(negedge clk);
    in_v = 1;
    in_pkt = {op, addr, data, 2'd0, 2'd0, dy, dx};
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    chk("in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_v = 0;
  endtask
  task automatic store(input [9:0] addr, input [31:0] data);
    send(2'd0, addr, data, 2'd0, 2'd0);
  endtask
  task automatic start(input [9:0] n, input [9:0] a, input [9:0] b);
    send(2'd1, n, {6'd0, b, 6'd0, a}, 2'd0, 2'd0);
  endtask
  task automatic expect_pkt(input string tag, input [9:0] n, input [31:0] d, input int lat);
    int cyc = 0;
    while (!out_v && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_op"}, opk[51:50], 3);
    chk({tag, "_n"}, opk[49:40], n);
    chk({tag, "_data"}, opk[39:8], d);
    chk({tag, "_src"}, opk[7:4], {my_y, my_x});
    chk({tag, "_dst"}, opk[3:0], {dest_y, dest_x});
  endtask
  task automatic ack();
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk("ack_idle", {out_v, in_ready}, 2'b01);
  endtask
  initial begin
    int bad;
    logic [P-1:0] saved;
    #12 chk("rst_out", so, 0);
    #10 reset_i = 1;
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (out_v !== 0 || in_ready !== 1 || $isunknown(so)) bad++;
    end
    chk("idle", bad, 0);
    for (int i = 0; i < 4; i++) begin
      store(10'(i), 32'(i + 1));
      store(10'(16 + i), 32'(i + 5));
    end
    start(4, 0, 16);
    expect_pkt("dot", 4, 70, 5);
    saved = opk;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_v !== 1 || in_ready !== 0 || opk !== saved) bad++;
    end
    chk("hold", bad, 0);
    chk("hold_data", opk[39:8], 70);
    ack();
    store(0, 3);
    send(2'd0, 0, 99, 2'd0, 2'd1);
    start(1, 0, 0);
    expect_pkt("filter", 1, 9, 2);
    ack();
    store(5, 6);
    start(1, 5, 5);
    expect_pkt("fresh", 1, 36, 2);
    ack();
    store(1023, 32'hFFFF_FFFF);
    store(200, 2);
    start(1, 1023, 200);
    expect_pkt("trunc", 1, 32'hFFFF_FFFE, 2);
    ack();
    store(0, 7);
    store(100, 2);
    store(101, 5);
    start(2, 1023, 100);
    expect_pkt("wrap", 2, 32'h21, 3);
    ack();
    dest_x = 2;
    dest_y = 3;
    start(0, 5, 5);
    expect_pkt("zero", 0, 0, 0);
    ack();
    dest_x = 1;
    dest_y = 1;
    start(8, 0, 0);
    repeat (3) @(posedge clk);
    #2 reset_i = 0;
    #1 chk("abort", so, 0);
    repeat (2) @(posedge clk);
    #2 reset_i = 1;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_v !== 0) bad++;
    end
    chk("no_pkt", bad, 0);
    chk("rel_ready", in_ready, 1);
    start(1, 0, 0);
    expect_pkt("again", 1, 49, 2);
    ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
